// File: rtl/encout_elc_out_gen_if.sv
// ENCOUT ELC event-output bundle: control inputs and
// event-line/status outputs of the pulse generator.
interface encout_elc_out_gen_if #(
  parameter int PW_W   = 4,
  parameter int PEND_W = 3
);
  logic              i_enable;
  logic              i_evt;
  logic [PW_W-1:0]   i_pulse_len;
  logic [PW_W-1:0]   i_gap_len;
  logic              i_ovf_clr;
  logic              o_elc_out;
  logic [PEND_W-1:0] o_pending;
  logic              o_busy;
  logic              o_ovf;

  modport master (
    output i_enable, i_evt, i_pulse_len,
    output i_gap_len, i_ovf_clr,
    input  o_elc_out, o_pending, o_busy, o_ovf
  );

  modport slave (
    input  i_enable, i_evt, i_pulse_len,
    input  i_gap_len, i_ovf_clr,
    output o_elc_out, o_pending, o_busy, o_ovf
  );
endinterface

// File: rtl/encout_elc_out_gen.sv
// ENCOUT ELC event-output generator: turns event strobes
// into registered fixed-width pulses with a minimum gap.
module encout_elc_out_gen #(
  parameter int PW_W   = 4,
  parameter int PEND_W = 3
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  encout_elc_out_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [PEND_W-1:0] PMAX = '1;

  state_t            state_q, state_d;
  logic [PW_W-1:0]   cnt_q, cnt_d;
  logic              elc_q, elc_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              start;
  logic              acc;
  logic              drop;
  logic              busy;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      elc_q   <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      elc_q   <= elc_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    elc_d   = elc_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_enable &&
            (bus.i_evt || pend_q != '0)) begin
          state_d = HIGH;
          cnt_d   = bus.i_pulse_len;
          elc_d   = 1'b1;
          start   = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = GAP;
          cnt_d   = bus.i_gap_len;
          elc_d   = 1'b0;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (pend_q != '0 && bus.i_enable) begin
          state_d = HIGH;
          cnt_d   = bus.i_pulse_len;
          elc_d   = 1'b1;
          start   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        elc_d   = 1'b0;
      end
    endcase
  end

  // A start in this edge frees a slot, so a full counter
  // still accepts the incoming event.
  always_comb begin
    drop = bus.i_enable & bus.i_evt &
           (pend_q == PMAX) & ~start;
    acc  = bus.i_enable & bus.i_evt &
           ~((pend_q == PMAX) & ~start);
    if (!bus.i_enable) begin
      pend_d = '0;
    end else begin
      pend_d = pend_q + PEND_W'(acc)
             - PEND_W'(start);
    end
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.i_ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_comb begin
    busy = (state_q != IDLE) || (pend_q != '0);
  end

  assign bus.o_elc_out = elc_q;
  assign bus.o_pending = pend_q;
  assign bus.o_busy    = busy;
  assign bus.o_ovf     = ovf_q;

endmodule

// File: tb/tb_encout_elc_out_gen.sv
// Directed self-checking bench for the ENCOUT ELC
// event-output generator.
module tb_encout_elc_out_gen;

  logic i_clk;
  logic i_resetn;
  int   n_assert;
  int   n_fail;
  int   rises;
  int   r0;
  int   pend_max;
  logic elc_prev;

  encout_elc_out_gen_if #(.PW_W(4), .PEND_W(3)) bus ();

  encout_elc_out_gen #(.PW_W(4), .PEND_W(3)) dut (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .bus      (bus.slave)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    rises    = 0;
    elc_prev = 1'b0;
  end

  always @(negedge i_clk) begin
    if (bus.o_elc_out && !elc_prev) rises = rises + 1;
    elc_prev = bus.o_elc_out;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // evt held for the first ne ticks; pat[i] is the
  // expected event line after tick i.
  task automatic wave(input string tag, input int ne,
                      input int n,
                      input logic [31:0] pat);
    for (int i = 0; i < n; i++) begin
      bus.i_evt = (i < ne);
      tick();
      if (int'(bus.o_pending) > pend_max)
        pend_max = int'(bus.o_pending);
      chk($sformatf("%s[%0d]", tag, i),
          {31'd0, bus.o_elc_out}, {31'd0, pat[i]});
    end
    bus.i_evt = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && bus.o_busy; i++)
      tick();
    chk(tag, {31'd0, bus.o_busy}, 32'd0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    pend_max = 0;
    i_resetn = 1'b0;
    bus.i_enable    = 1'b1;
    bus.i_evt       = 1'b0;
    bus.i_pulse_len = 4'd2;
    bus.i_gap_len   = 4'd1;
    bus.i_ovf_clr   = 1'b0;
    #3;
    chk("rst_elc", {31'd0, bus.o_elc_out}, 32'd0);
    chk("rst_pend", {29'd0, bus.o_pending}, 32'd0);
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst_ovf", {31'd0, bus.o_ovf}, 32'd0);
    tick();
    tick();
    i_resetn = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // single event, P=2 G=1
    wave("single", 1, 6, 32'h07);
    chk("single_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("single_pend", {29'd0, bus.o_pending}, 32'd0);

    // burst of 4, P=0 G=0
    bus.i_pulse_len = 4'd0;
    bus.i_gap_len   = 4'd0;
    pend_max = 0;
    r0 = rises;
    wave("burst", 4, 9, 32'h055);
    chk("burst_pmax", pend_max, 32'd2);
    chk("burst_ovf", {31'd0, bus.o_ovf}, 32'd0);
    chk("burst_busy", {31'd0, bus.o_busy}, 32'd0);
    tick();
    chk("burst_rises", rises - r0, 32'd4);

    // saturation, P=15 G=15
    bus.i_pulse_len = 4'd15;
    bus.i_gap_len   = 4'd15;
    r0 = rises;
    wave("sat", 10, 10, 32'h3FF);
    chk("sat_pend", {29'd0, bus.o_pending}, 32'd7);
    chk("sat_ovf", {31'd0, bus.o_ovf}, 32'd1);
    drain("sat_drain");
    tick();
    chk("sat_rises", rises - r0, 32'd8);
    bus.i_ovf_clr = 1'b1;
    tick();
    bus.i_ovf_clr = 1'b0;
    chk("ovf_clr", {31'd0, bus.o_ovf}, 32'd0);
    wave("resat", 8, 8, 32'hFF);
    chk("resat_pend", {29'd0, bus.o_pending}, 32'd7);
    bus.i_evt     = 1'b1;
    bus.i_ovf_clr = 1'b1;
    tick();
    bus.i_evt     = 1'b0;
    bus.i_ovf_clr = 1'b0;
    chk("ovf_set_wins", {31'd0, bus.o_ovf}, 32'd1);
    bus.i_enable = 1'b0;
    tick();
    chk("dis_pend", {29'd0, bus.o_pending}, 32'd0);
    drain("resat_drain");
    bus.i_enable = 1'b1;
    bus.i_ovf_clr = 1'b1;
    tick();
    bus.i_ovf_clr = 1'b0;

    // disable during the second pulse, P=5 G=3
    bus.i_pulse_len = 4'd5;
    bus.i_gap_len   = 4'd3;
    wave("dis_a", 3, 12, 32'hC3F);
    chk("dis_pend_a", {29'd0, bus.o_pending}, 32'd1);
    bus.i_enable = 1'b0;
    tick();
    chk("dis_pend_b", {29'd0, bus.o_pending}, 32'd0);
    chk("dis_elc_b", {31'd0, bus.o_elc_out}, 32'd1);
    bus.i_evt = 1'b1;
    tick();
    bus.i_evt = 1'b0;
    chk("dis_evt_pend", {29'd0, bus.o_pending}, 32'd0);
    chk("dis_evt_ovf", {31'd0, bus.o_ovf}, 32'd0);
    wave("dis_b", 0, 12, 32'h003);
    chk("dis_busy", {31'd0, bus.o_busy}, 32'd0);
    bus.i_enable = 1'b1;

    // async reset mid-HIGH, P=3 G=0
    bus.i_pulse_len = 4'd3;
    bus.i_gap_len   = 4'd0;
    bus.i_evt = 1'b1;
    tick();
    bus.i_evt = 1'b0;
    chk("ar_high", {31'd0, bus.o_elc_out}, 32'd1);
    #2;
    i_resetn = 1'b0;
    #1;
    chk("ar_elc", {31'd0, bus.o_elc_out}, 32'd0);
    chk("ar_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("ar_pend", {29'd0, bus.o_pending}, 32'd0);
    chk("ar_ovf", {31'd0, bus.o_ovf}, 32'd0);
    #2;
    i_resetn = 1'b1;
    tick();
    chk("ar_idle", {31'd0, bus.o_elc_out}, 32'd0);
    chk("ar_idle_busy", {31'd0, bus.o_busy}, 32'd0);
    wave("ar_pulse", 1, 6, 32'h0F);
    chk("ar_done", {31'd0, bus.o_busy}, 32'd0);

    // pulse length changed from 3 to 0 mid-pulse
    bus.i_evt = 1'b1;
    tick();
    chk("cfg_e0", {31'd0, bus.o_elc_out}, 32'd1);
    tick();
    bus.i_evt = 1'b0;
    bus.i_pulse_len = 4'd0;
    chk("cfg_e1", {31'd0, bus.o_elc_out}, 32'd1);
    chk("cfg_pend", {29'd0, bus.o_pending}, 32'd1);
    wave("cfg", 0, 7, 32'h0B);
    chk("cfg_busy", {31'd0, bus.o_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
